// File: rtl/output_fill_array_2d.sv
// Multi-channel 2D output-buffer write-address generator with per-channel ping-pong bank.
// Latency: start at edge N -> first write address in cycle N+1, one address per non-empty cycle.
// Backpressure: is_empty stalls a channel's counters for that cycle; abort returns it to IDLE.
module output_fill_array_2d #(
    parameter int NUM_CH   = 9,
    parameter int ADDR_W   = 14,
    parameter int DIM_W    = 16,
    parameter int PINGPONG = 1
) (
    input  logic                     w_clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        start,
    input  logic [NUM_CH-1:0]        abort,
    input  logic [ADDR_W-1:0]        base_address,
    input  logic [ADDR_W-1:0]        bank_offset,
    input  logic [DIM_W-1:0]         fmap_width,
    input  logic [DIM_W-1:0]         fmap_height,
    input  logic [ADDR_W-1:0]        row_pitch,
    input  logic [NUM_CH-1:0]        is_empty,
    output logic [NUM_CH*ADDR_W-1:0] c_address,
    output logic [NUM_CH-1:0]        write_enable,
    output logic [NUM_CH-1:0]        busy,
    output logic [NUM_CH-1:0]        done,
    output logic [NUM_CH-1:0]        bank
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g = g + 1) begin : g_ch
            state_t            state;
            logic [ADDR_W-1:0] addr;
            logic [ADDR_W-1:0] row_base;
            logic [ADDR_W-1:0] pitch;
            logic [DIM_W-1:0]  col;
            logic [DIM_W-1:0]  row;
            logic [DIM_W-1:0]  w;
            logic [DIM_W-1:0]  h;
            logic              bank_r;
            logic [ADDR_W-1:0] start_base;
            logic              last_col;
            logic              last_row;
            logic              zero_tile;
            logic              do_write;

            // First address of a new tile: bank 1 places the tile bank_offset above base.
            assign start_base = base_address + (bank_r ? bank_offset : '0);

            // Position of the current element inside the latched tile geometry.
            assign last_col  = (col == (w - DIM_W'(1)));
            assign last_row  = (row == (h - DIM_W'(1)));
            assign zero_tile = (fmap_width == '0) || (fmap_height == '0);

            // A write is issued whenever the channel is filling and a result is available.
            assign do_write = (state == ST_FILL) && !is_empty[g];

            // Per-channel fill sequencer: tile walk, completion pulse and bank toggle.
            always_ff @(posedge w_clk or posedge reset) begin
                if (reset) begin
                    state    <= ST_IDLE;
                    addr     <= '0;
                    row_base <= '0;
                    pitch    <= '0;
                    col      <= '0;
                    row      <= '0;
                    w        <= '0;
                    h        <= '0;
                    bank_r   <= 1'b0;
                end else if (abort[g]) begin
                    // Abort wins over everything, including a simultaneous start
                    // and the bank toggle of a DONE cycle.
                    state <= ST_IDLE;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (start[g]) begin
                                w        <= fmap_width;
                                h        <= fmap_height;
                                pitch    <= row_pitch;
                                row_base <= start_base;
                                addr     <= start_base;
                                col      <= '0;
                                row      <= '0;
                                // Empty tiles complete immediately without a single write.
                                state    <= zero_tile ? ST_DONE : ST_FILL;
                            end
                        end
                        ST_FILL: begin
                            if (do_write) begin
                                if (!last_col) begin
                                    col  <= col + DIM_W'(1);
                                    addr <= addr + ADDR_W'(1);
                                end else if (!last_row) begin
                                    col      <= '0;
                                    row      <= row + DIM_W'(1);
                                    row_base <= row_base + pitch;
                                    addr     <= row_base + pitch;
                                end else begin
                                    state <= ST_DONE;
                                end
                            end
                        end
                        ST_DONE: begin
                            if (PINGPONG != 0) begin
                                bank_r <= ~bank_r;
                            end
                            state <= ST_IDLE;
                        end
                        default: begin
                            state <= ST_IDLE;
                        end
                    endcase
                end
            end

            assign c_address[g*ADDR_W +: ADDR_W] = addr;
            assign write_enable[g]               = do_write;
            assign busy[g]                       = (state == ST_FILL);
            assign done[g]                       = (state == ST_DONE);
            assign bank[g]                       = bank_r;
        end
    endgenerate

endmodule

// File: tb/tb_output_fill_array_2d.sv
// Self-checking bench for output_fill_array_2d with a closed-form address model.
// A second instance with PINGPONG=0 shares every input and is checked alongside.
// Inputs change #1 after the rising edge; outputs are sampled a further #1 later.
module tb_output_fill_array_2d;

    localparam int NUM_CH = 9;
    localparam int ADDR_W = 14;
    localparam int DIM_W  = 16;
    localparam int AMASK  = (1 << ADDR_W) - 1;

    logic                     w_clk = 1'b0;
    logic                     reset;
    logic [NUM_CH-1:0]        start;
    logic [NUM_CH-1:0]        abort;
    logic [ADDR_W-1:0]        base_address;
    logic [ADDR_W-1:0]        bank_offset;
    logic [DIM_W-1:0]         fmap_width;
    logic [DIM_W-1:0]         fmap_height;
    logic [ADDR_W-1:0]        row_pitch;
    logic [NUM_CH-1:0]        is_empty;
    logic [NUM_CH*ADDR_W-1:0] c_address;
    logic [NUM_CH-1:0]        write_enable;
    logic [NUM_CH-1:0]        busy;
    logic [NUM_CH-1:0]        done;
    logic [NUM_CH-1:0]        bank;
    logic [NUM_CH*ADDR_W-1:0] np_c_address;
    logic [NUM_CH-1:0]        np_write_enable;
    logic [NUM_CH-1:0]        np_busy;
    logic [NUM_CH-1:0]        np_done;
    logic [NUM_CH-1:0]        np_bank;

    int checks = 0;
    int errors = 0;
    int bank_m[NUM_CH];

    output_fill_array_2d #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .PINGPONG(1)) dut (
        .w_clk(w_clk), .reset(reset), .start(start), .abort(abort),
        .base_address(base_address), .bank_offset(bank_offset),
        .fmap_width(fmap_width), .fmap_height(fmap_height), .row_pitch(row_pitch),
        .is_empty(is_empty), .c_address(c_address), .write_enable(write_enable),
        .busy(busy), .done(done), .bank(bank)
    );

    output_fill_array_2d #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DIM_W(DIM_W), .PINGPONG(0)) dut_np (
        .w_clk(w_clk), .reset(reset), .start(start), .abort(abort),
        .base_address(base_address), .bank_offset(bank_offset),
        .fmap_width(fmap_width), .fmap_height(fmap_height), .row_pitch(row_pitch),
        .is_empty(is_empty), .c_address(np_c_address), .write_enable(np_write_enable),
        .busy(np_busy), .done(np_done), .bank(np_bank)
    );

    always #5 w_clk = ~w_clk;

    // Address of element (r, c) of a tile: plain 2D arithmetic, wrapped to the buffer size.
    function automatic int model_addr(int base, int boff, int bk, int r, int c, int pitch);
        return (base + ((bk != 0) ? boff : 0) + r * pitch + c) & AMASK;
    endfunction

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    // Runs one tile on one channel and checks every write against the model.
    // mode 0: source never empty, 1: empty on alternate cycles (first one empty), 2: random.
    task automatic run_tile(input int ch, input int base, input int boff, input int wd,
                            input int ht, input int pitch, input int mode, input string tag);
        int q[$];
        int qn[$];
        int cyc, writes, empties, got_done, e, bound, a, exp_a, last_a;
        last_a = 0;
        for (int r = 0; r < ht; r++) begin
            for (int c = 0; c < wd; c++) begin
                q.push_back(model_addr(base, boff, bank_m[ch], r, c, pitch));
                qn.push_back(model_addr(base, boff, 0, r, c, pitch));
            end
        end
        base_address = ADDR_W'(base);
        bank_offset  = ADDR_W'(boff);
        fmap_width   = DIM_W'(wd);
        fmap_height  = DIM_W'(ht);
        row_pitch    = ADDR_W'(pitch);
        start[ch]    = 1'b1;
        tick();
        start[ch] = 1'b0;
        cyc = 0; writes = 0; empties = 0; got_done = 0;
        bound = 4 * wd * ht + 20;
        while (1) begin
            if (mode == 0)      e = 0;
            else if (mode == 1) e = (cyc % 2 == 0) ? 1 : 0;
            else                e = ($urandom_range(0, 99) < 30) ? 1 : 0;
            is_empty[ch] = e[0];
            #1;
            cyc++;
            if (done[ch] === 1'b1) begin
                got_done = 1;
                checks++;
                if (write_enable[ch] !== 1'b0 || np_done[ch] !== 1'b1) begin
                    errors++;
                    $display("FAIL %s done_cycle ch%0d: we=%b np_done=%b, need we=0 np_done=1",
                             tag, ch, write_enable[ch], np_done[ch]);
                end
                break;
            end
            if (cyc > bound) break;
            checks++;
            if (busy[ch] !== 1'b1 || write_enable[ch] !== !e[0] || np_write_enable[ch] !== !e[0]) begin
                errors++;
                $display("FAIL %s fill_flags ch%0d cyc%0d: busy=%b we=%b np_we=%b, need busy=1 we=%b",
                         tag, ch, cyc, busy[ch], write_enable[ch], np_write_enable[ch], !e[0]);
            end
            if (write_enable[ch] === 1'b1) begin
                writes++;
                a = int'(c_address[ch*ADDR_W +: ADDR_W]);
                exp_a = (q.size() > 0) ? q.pop_front() : -1;
                last_a = exp_a;
                checks++;
                if (a !== exp_a) begin
                    errors++;
                    $display("FAIL %s addr ch%0d write%0d: got %h expected %h", tag, ch, writes, a, exp_a);
                end
                a = int'(np_c_address[ch*ADDR_W +: ADDR_W]);
                exp_a = (qn.size() > 0) ? qn.pop_front() : -1;
                checks++;
                if (a !== exp_a) begin
                    errors++;
                    $display("FAIL %s np_addr ch%0d write%0d: got %h expected %h", tag, ch, writes, a, exp_a);
                end
            end else begin
                empties++;
            end
            tick();
        end
        checks++;
        if (got_done != 1) begin
            errors++;
            $display("FAIL %s timeout ch%0d: no done within %0d cycles, need done", tag, ch, bound);
        end
        checks++;
        if (writes != wd * ht || cyc != wd * ht + empties + 1) begin
            errors++;
            $display("FAIL %s count ch%0d: writes=%0d done_cycle=%0d, need writes=%0d done_cycle=%0d",
                     tag, ch, writes, cyc, wd * ht, wd * ht + empties + 1);
        end
        if (got_done == 1) bank_m[ch] = bank_m[ch] ^ 1;
        tick();
        checks++;
        if (bank[ch] !== bank_m[ch][0] || np_bank[ch] !== 1'b0 || busy[ch] !== 1'b0 || done[ch] !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done ch%0d: bank=%b np_bank=%b busy=%b done=%b, need bank=%0d np_bank=0 busy=0 done=0",
                     tag, ch, bank[ch], np_bank[ch], busy[ch], done[ch], bank_m[ch]);
        end
        if (wd * ht > 0) begin
            a = int'(c_address[ch*ADDR_W +: ADDR_W]);
            checks++;
            if (a !== last_a) begin
                errors++;
                $display("FAIL %s idle_hold ch%0d: got %h expected %h", tag, ch, a, last_a);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (c_address !== '0 || write_enable !== '0 || busy !== '0 || done !== '0 || bank !== '0) begin
            errors++;
            $display("FAIL reset_values: addr=%h we=%b busy=%b done=%b bank=%b, need all 0",
                     c_address, write_enable, busy, done, bank);
        end
        @(posedge w_clk);
        @(posedge w_clk);
        #1;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run_tile(0, 'h100, 0, 3, 2, 8, 0, "basic");
    endtask

    task automatic test_back_to_back_pingpong();
        run_tile(0, 'h100, 'h400, 3, 2, 8, 0, "pingpong_b1");
        run_tile(0, 'h100, 'h400, 3, 2, 8, 0, "pingpong_b0");
    endtask

    task automatic test_backpressure();
        run_tile(2, 'h040, 0, 2, 2, 16, 1, "backpressure");
    endtask

    task automatic test_abort();
        int seen;
        is_empty[1] = 1'b0;
        start[1] = 1'b1;
        abort[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        abort[1] = 1'b0;
        #1;
        checks++;
        if (busy[1] !== 1'b0 || write_enable[1] !== 1'b0 || done[1] !== 1'b0) begin
            errors++;
            $display("FAIL abort_with_start: busy=%b we=%b done=%b, need 0 0 0", busy[1], write_enable[1], done[1]);
        end
        tick();
        base_address = 14'h0200; bank_offset = 14'h0010;
        fmap_width = 16'd4; fmap_height = 16'd2; row_pitch = 14'd8;
        start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        tick();
        tick();
        is_empty[1] = 1'b1;
        abort[1] = 1'b1;
        tick();
        abort[1] = 1'b0;
        is_empty[1] = 1'b0;
        #1;
        checks++;
        if (busy[1] !== 1'b0 || write_enable[1] !== 1'b0 || bank[1] !== bank_m[1][0]) begin
            errors++;
            $display("FAIL abort_mid_fill: busy=%b we=%b bank=%b, need busy=0 we=0 bank=%0d",
                     busy[1], write_enable[1], bank[1], bank_m[1]);
        end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (done[1] === 1'b1 || busy[1] === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_done: active cycles %0d, need 0", seen);
        end
        run_tile(1, 'h200, 'h10, 4, 2, 8, 0, "abort_restart");
    endtask

    task automatic test_wrap_independence();
        int a, exp_a;
        is_empty = '0;
        base_address = 14'h3FFE; bank_offset = 14'h0000;
        fmap_width = 16'd4; fmap_height = 16'd1; row_pitch = 14'd1;
        start[3] = 1'b1;
        tick();
        start[3] = 1'b0;
        start[5] = 1'b1;
        fmap_width = 16'd0;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (write_enable[3] !== (k < 4) || done[3] !== (k == 4)) begin
                errors++;
                $display("FAIL wrap_flags ch3 k%0d: we=%b done=%b, need we=%b done=%b",
                         k, write_enable[3], done[3], (k < 4), (k == 4));
            end
            if (k < 4) begin
                a = int'(c_address[3*ADDR_W +: ADDR_W]);
                exp_a = model_addr('h3FFE, 0, bank_m[3], 0, k, 1);
                checks++;
                if (a !== exp_a) begin
                    errors++;
                    $display("FAIL wrap_addr ch3 k%0d: got %h expected %h", k, a, exp_a);
                end
            end
            checks++;
            if (write_enable[5] !== 1'b0 || busy[5] !== 1'b0 || done[5] !== (k == 1)) begin
                errors++;
                $display("FAIL zero_tile ch5 k%0d: we=%b busy=%b done=%b, need we=0 busy=0 done=%b",
                         k, write_enable[5], busy[5], done[5], (k == 1));
            end
            tick();
            if (k == 0) start[5] = 1'b0;
        end
        bank_m[3] = bank_m[3] ^ 1;
        bank_m[5] = bank_m[5] ^ 1;
        checks++;
        if (bank[3] !== bank_m[3][0] || bank[5] !== bank_m[5][0]) begin
            errors++;
            $display("FAIL wrap_banks: ch3=%b ch5=%b, need ch3=%0d ch5=%0d", bank[3], bank[5], bank_m[3], bank_m[5]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 14; n++) begin
            run_tile($urandom_range(0, NUM_CH - 1), $urandom_range(0, AMASK), $urandom_range(0, AMASK),
                     $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, AMASK), 2, "random");
        end
    endtask

    task automatic test_reset_midfill();
        int seen;
        is_empty = '0;
        base_address = 14'h0020; bank_offset = 14'h0100;
        fmap_width = 16'd5; fmap_height = 16'd3; row_pitch = 14'd7;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        tick();
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (c_address !== '0 || write_enable !== '0 || busy !== '0 || done !== '0 || bank !== '0 ||
            np_c_address !== '0 || np_busy !== '0) begin
            errors++;
            $display("FAIL reset_async: addr=%h we=%b busy=%b done=%b bank=%b, need all 0",
                     c_address, write_enable, busy, done, bank);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < NUM_CH; i++) bank_m[i] = 0;
        seen = 0;
        for (int k = 0; k < 25; k++) begin
            #1;
            if (done !== '0 || busy !== '0 || write_enable !== '0 || c_address !== '0) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_release: active cycles %0d, need 0", seen);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = '0; abort = '0; is_empty = '0;
        base_address = '0; bank_offset = '0; row_pitch = '0;
        fmap_width = '0; fmap_height = '0;
        for (int i = 0; i < NUM_CH; i++) bank_m[i] = 0;
        test_reset();
        test_basic();
        test_back_to_back_pingpong();
        test_backpressure();
        test_abort();
        test_wrap_independence();
        test_random();
        test_reset_midfill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
